// File: rtl/accum_pkg.sv
// Shared state encoding, default widths and the sign-extension helper for
// the accumulating arbiter and its datapath.
package accum_pkg;

    localparam int DEF_NREQ = 4;
    localparam int DEF_DW   = 20;
    localparam int DEF_AW   = 38;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Sign-extend the low w bits of x to 64 bits; callers truncate to their width.
    function automatic logic [63:0] sext(input logic [63:0] x, input int unsigned w);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        return x[w[5:0] - 6'd1] ? (x | ~mask) : (x & mask);
    endfunction

endpackage

// File: rtl/accum_core.sv
// Add/subtract accumulator register: clear wins over enable, arithmetic wraps
// modulo 2^AW.
module accum_core
    import accum_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          en,
    input  logic          sub,
    input  logic [DW-1:0] sample,
    output logic [AW-1:0] acc
);

    logic [AW-1:0] operand;

    assign operand = AW'(sext(64'(sample), DW));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= sub ? (acc - operand) : (acc + operand);
        end
    end

endmodule

// File: rtl/accum_arbiter.sv
// Round-robin arbiter that grants one requester a whole burst into a shared
// accumulator and presents the burst total as a single result.
module accum_arbiter
    import accum_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    parameter  int DW   = DEF_DW,
    parameter  int AW   = DEF_AW,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ-1:0]    req_sub,
    input  logic [NREQ-1:0]    req_last,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [IW-1:0]      res_id,
    output logic [AW-1:0]      res_data
);

    // Handshake: a sample moves when req_valid[i] && req_ready[i] at a rising
    // edge; a result moves when res_valid && res_ready. Outputs never depend
    // combinationally on the valid/ready inputs.

    state_t        state, state_next;
    logic [IW-1:0] grant, rr_ptr, pick, next_ptr;
    logic          found;
    logic          core_clear, core_en;
    logic [AW-1:0] acc;
    logic [DW-1:0] grant_sample;
    int            idx;

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(rr_ptr) + i) % NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
    end

    assign grant_sample = req_data[int'(grant)*DW +: DW];
    assign next_ptr     = (grant == IW'(NREQ - 1)) ? '0 : grant + 1'b1;

    always_comb begin
        state_next = state;
        req_ready  = '0;
        res_valid  = 1'b0;
        res_data   = '0;
        res_id     = '0;
        core_clear = 1'b0;
        core_en    = 1'b0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_next = ACCUM;
                    core_clear = 1'b1;
                end
            end
            ACCUM: begin
                req_ready[grant] = 1'b1;
                if (req_valid[grant]) begin
                    core_en = 1'b1;
                    if (req_last[grant]) state_next = DRAIN;
                end
            end
            DRAIN: begin
                res_valid = 1'b1;
                res_data  = acc;
                res_id    = grant;
                if (res_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && found) grant <= pick;
            if (state == DRAIN && res_ready) rr_ptr <= next_ptr;
        end
    end

    accum_core #(
        .DW(DW),
        .AW(AW)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .clear (core_clear),
        .en    (core_en),
        .sub   (req_sub[grant]),
        .sample(grant_sample),
        .acc   (acc)
    );

endmodule

// File: tb/tb_accum_arbiter.sv
// Bench for accum_arbiter: randomized and directed bursts scored against a
// transaction-level model of round-robin grants and burst sums.
module tb_accum_arbiter;
    import accum_pkg::*;

    localparam int NREQ = 4;
    localparam int DW   = 20;
    localparam int AW   = 38;
    localparam int IW   = 2;
    localparam int WAW  = 24;

    typedef struct {
        logic [DW-1:0] data;
        bit            sub;
        bit            last;
        int            gap;
    } item_t;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [NREQ-1:0]    req_valid, req_ready, req_sub, req_last;
    logic [NREQ*DW-1:0] req_data;
    logic               res_valid, res_ready;
    logic [IW-1:0]      res_id;
    logic [AW-1:0]      res_data;

    logic [NREQ-1:0]    w_valid = '0, w_ready, w_sub = '0, w_last = '0;
    logic [NREQ*DW-1:0] w_data = '0;
    logic               w_res_valid;
    logic               w_res_ready = 1'b1;
    logic [IW-1:0]      w_res_id;
    logic [WAW-1:0]     w_res_data;

    item_t req_q[NREQ][$];
    item_t drv_t;
    bit    accepted[NREQ];
    int    ready_mode = 0;
    int    n_checks = 0;
    int    n_pass = 0;

    // Reference model state
    bit            m_armed = 1'b0;
    int            m_owner = -1;
    bit            m_res_pend = 1'b0;
    int            m_ptr = 0;
    longint        m_sum = 0;
    int            xfer_cnt = 0;
    logic [NREQ-1:0] m_exp_ready;
    logic [AW-1:0] m_exp_data;
    logic [DW-1:0] m_s;

    always #5 clk = ~clk;

    accum_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_sub(req_sub), .req_last(req_last),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_data(res_data)
    );

    // Narrow accumulator copy so wrap-around is reachable in a short run.
    accum_arbiter #(.NREQ(NREQ), .DW(DW), .AW(WAW)) u_wrap (
        .clk(clk), .reset(reset), .req_valid(w_valid), .req_ready(w_ready),
        .req_data(w_data), .req_sub(w_sub), .req_last(w_last),
        .res_valid(w_res_valid), .res_ready(w_res_ready), .res_id(w_res_id), .res_data(w_res_data)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic push(input int r, input int val, input bit sub, input bit last, input int gap);
        item_t t;
        t.data = val[DW-1:0];
        t.sub  = sub;
        t.last = last;
        t.gap  = gap;
        req_q[r].push_back(t);
    endtask

    task automatic push_rand_burst(input int r);
        int len, val;
        len = $urandom_range(1, 6);
        for (int j = 0; j < len; j++) begin
            case ($urandom_range(0, 4))
                0:       val = 32'h7FFFF;
                1:       val = 32'h80000;
                default: val = int'($urandom);
            endcase
            push(r, val, 1'($urandom_range(0, 1)), j == len - 1, $urandom_range(0, 2));
        end
    endtask

    // Driver: pops accepted samples, presents the queue head after its gap.
    initial begin
        req_valid = '0;
        req_sub   = '0;
        req_last  = '0;
        req_data  = '0;
        res_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (accepted[i]) begin
                    accepted[i] = 1'b0;
                    if (req_q[i].size() > 0) void'(req_q[i].pop_front());
                end
                req_valid[i] = 1'b0;
                if (req_q[i].size() > 0) begin
                    drv_t = req_q[i][0];
                    if (drv_t.gap > 0) begin
                        drv_t.gap--;
                        req_q[i][0] = drv_t;
                    end else begin
                        req_valid[i]           = 1'b1;
                        req_data[i*DW +: DW]   = drv_t.data;
                        req_sub[i]             = drv_t.sub;
                        req_last[i]            = drv_t.last;
                    end
                end
            end
            case (ready_mode)
                0:       res_ready = 1'b1;
                1:       res_ready = 1'b0;
                default: res_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Compare process: check outputs against the model, then advance the model
    // by what the next rising edge will do with the inputs now on the pins.
    initial begin
        forever begin
            @(negedge clk);
            if (m_armed) begin
                m_exp_ready = (m_owner >= 0 && !m_res_pend) ? NREQ'(1 << m_owner) : '0;
                check("req_ready", 64'(req_ready), 64'(m_exp_ready));
                check("res_valid", 64'(res_valid), 64'(m_res_pend));
                if (m_res_pend) begin
                    m_exp_data = AW'(m_sum);
                    check("res_data", 64'(res_data), 64'(m_exp_data));
                    check("res_id", 64'(res_id), 64'(m_owner[IW-1:0]));
                end
            end
            if (reset) begin
                m_owner    = -1;
                m_res_pend = 1'b0;
                m_ptr      = 0;
                m_sum      = 0;
                m_armed    = 1'b1;
            end else if (m_armed) begin
                if (m_res_pend) begin
                    if (res_ready) begin
                        m_res_pend = 1'b0;
                        m_ptr      = (m_owner + 1) % NREQ;
                        m_owner    = -1;
                    end
                end else if (m_owner >= 0) begin
                    if (req_valid[m_owner]) begin
                        m_s = req_data[m_owner*DW +: DW];
                        if (req_sub[m_owner]) m_sum = m_sum - longint'($signed(m_s));
                        else m_sum = m_sum + longint'($signed(m_s));
                        xfer_cnt++;
                        accepted[m_owner] = 1'b1;
                        if (req_last[m_owner]) m_res_pend = 1'b1;
                    end
                end else begin
                    for (int k = 0; k < NREQ; k++) begin
                        if (m_owner < 0 && req_valid[(m_ptr + k) % NREQ]) begin
                            m_owner = (m_ptr + k) % NREQ;
                            m_sum   = 0;
                        end
                    end
                end
            end
        end
    end

    task automatic wait_result(output int id, output logic [AW-1:0] data);
        bit got = 1'b0;
        id   = -1;
        data = '0;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge clk);
            if (res_valid && res_ready) begin
                got  = 1'b1;
                id   = int'(res_id);
                data = res_data;
            end
        end
        if (!got) check("result_timeout", 64'(got), 64'd1);
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clk);
            #1;
            done = (m_owner < 0) && !m_res_pend;
            for (int i = 0; i < NREQ; i++) if (req_q[i].size() > 0) done = 1'b0;
        end
        if (!done) check("drain_timeout", 64'(done), 64'd1);
    endtask

    task automatic run_wrap(input int n, input logic [WAW-1:0] expv);
        int sent = 0;
        bit got = 1'b0;
        @(posedge clk);
        #1;
        w_data[DW-1:0] = 20'h7FFFF;
        w_last         = '0;
        w_last[0]      = (n == 1);
        w_valid        = 4'b0001;
        for (int c = 0; c < 300 && sent < n; c++) begin
            @(negedge clk);
            if (w_ready[0]) sent++;
            @(posedge clk);
            #1;
            w_last[0] = (sent == n - 1);
            if (sent == n) w_valid = '0;
        end
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (w_res_valid) begin
                got = 1'b1;
                check("wrap_data", 64'(w_res_data), 64'(expv));
                check("wrap_id", 64'(w_res_id), 64'd0);
            end
        end
        if (!got) check("wrap_timeout", 64'(got), 64'd1);
    endtask

    initial begin
        int id;
        logic [AW-1:0] d, e;
        int base;
        bit seen;

        // Both requesters 0 and 1 valid from reset; 0 has two bursts queued.
        push(0, 10, 1'b0, 1'b1, 0);
        push(0, 10, 1'b0, 1'b1, 0);
        push(1, 10, 1'b0, 1'b1, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_res_data", 64'(res_data), 64'd0);
        check("rst_res_id", 64'(res_id), 64'd0);
        @(posedge clk);
        #2 reset = 1'b0;
        e = 10;
        wait_result(id, d);
        check("rr_first_id", 64'(id), 64'd0);
        check("rr_first_data", 64'(d), 64'(e));
        wait_result(id, d);
        check("rr_second_id", 64'(id), 64'd1);
        check("rr_second_data", 64'(d), 64'(e));
        wait_result(id, d);
        check("rr_third_id", 64'(id), 64'd0);

        // Three-sample burst on requester 2.
        push(2, 5, 1'b0, 1'b0, 0);
        push(2, 7, 1'b0, 1'b0, 0);
        push(2, -3, 1'b0, 1'b1, 0);
        wait_result(id, d);
        e = 9;
        check("burst3_data", 64'(d), 64'(e));
        check("burst3_id", 64'(id), 64'd2);

        // Result held under back-pressure while requester 1 keeps asking.
        ready_mode = 1;
        push(0, 100, 1'b0, 1'b0, 0);
        push(0, 250, 1'b1, 1'b1, 0);
        push(1, 7, 1'b0, 1'b1, 0);
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            seen = res_valid;
        end
        check("hold_seen", 64'(seen), 64'd1);
        e = -150;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            check("hold_data", 64'(res_data), 64'(e));
            check("hold_id", 64'(res_id), 64'd0);
            check("hold_valid", 64'(res_valid), 64'd1);
            check("hold_req_ready", 64'(req_ready), 64'd0);
        end
        ready_mode = 0;
        wait_result(id, d);
        check("sub_data", 64'(d), 64'(e));
        wait_result(id, d);
        e = 7;
        check("after_hold_id", 64'(id), 64'd1);
        check("after_hold_data", 64'(d), 64'(e));

        // Reset after the third of five samples.
        base = xfer_cnt;
        push(1, 1, 1'b0, 1'b0, 0);
        push(1, 2, 1'b0, 1'b0, 0);
        push(1, 3, 1'b0, 1'b0, 0);
        push(1, 4, 1'b0, 1'b0, 0);
        push(1, 5, 1'b0, 1'b1, 0);
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            #1;
            seen = (xfer_cnt == base + 3);
        end
        check("midrst_seen", 64'(seen), 64'd1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        for (int i = 0; i < NREQ; i++) req_q[i].delete();
        req_valid = '0;
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("midrst_req_ready", 64'(req_ready), 64'd0);
        check("midrst_res_valid", 64'(res_valid), 64'd0);
        check("midrst_res_data", 64'(res_data), 64'd0);
        check("midrst_res_id", 64'(res_id), 64'd0);
        // Pointer back at 0: requester 1 must win over requester 3.
        push(3, 20, 1'b0, 1'b1, 0);
        push(1, 30, 1'b0, 1'b1, 0);
        wait_result(id, d);
        e = 30;
        check("postrst_id", 64'(id), 64'd1);
        check("postrst_data", 64'(d), 64'(e));
        wait_result(id, d);
        e = 20;
        check("postrst_id2", 64'(id), 64'd3);
        check("postrst_data2", 64'(d), 64'(e));

        // Bubbles: valid 1,0,0,1 across samples 4 and 6.
        push(3, 4, 1'b0, 1'b0, 0);
        push(3, 6, 1'b0, 1'b1, 2);
        wait_result(id, d);
        e = 10;
        check("bubble_data", 64'(d), 64'(e));
        check("bubble_id", 64'(id), 64'd3);

        // Wrap of the 24-bit accumulator: 17 and 40 samples of 2^19-1.
        run_wrap(17, 24'd8912879);
        run_wrap(40, 24'd4194264);

        // Randomized contention with random back-pressure.
        ready_mode = 2;
        for (int round = 0; round < 60; round++) begin
            for (int r = 0; r < NREQ; r++) begin
                if ($urandom_range(0, 1) == 1) push_rand_burst(r);
                if ($urandom_range(0, 3) == 0) push_rand_burst(r);
            end
            wait_idle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/accum_arbiter.md
ACCUM_ARBITER -- requirements
Module: accum_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one accumulator.
REQ-002 Parameter DW, default 20, signed sample width.
REQ-003 Parameter AW, default 38, signed accumulator/result width.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  NREQ  per-requester sample valid.
REQ-007 req_ready  output  NREQ  per-requester sample accepted; at most one bit high.
REQ-008 req_data  input  NREQ*DW  packed signed samples, requester i at bits [i*DW +: DW].
REQ-009 req_sub  input  NREQ  1 = subtract sample, 0 = add.
REQ-010 req_last  input  NREQ  marks final sample of a burst.
REQ-011 res_valid  output  1  result available.
REQ-012 res_ready  input  1  downstream accepts result.
REQ-013 res_id  output  clog2(NREQ)  owner of presented result.
REQ-014 res_data  output  AW  signed accumulated result.

Function
REQ-015 FSM states IDLE, ACCUM, DRAIN; reset enters IDLE.
REQ-016 IDLE: if any req_valid, grant the first requester at or after rr_ptr (round-robin, wrapping), and go to ACCUM in the next cycle with accumulator = 0; no sample is accepted in IDLE.
REQ-017 ACCUM: req_ready[grant] = 1, all other bits 0; a transfer occurs when req_valid[grant] && req_ready[grant].
REQ-018 On each transfer, acc <= acc + sext(data) or acc - sext(data) per req_sub, modulo 2^AW (two's-complement wrap, no saturation, no flag).
REQ-019 Transfer with req_last = 1: go to DRAIN; res_valid high the following cycle, res_data = updated acc, res_id = grant.
REQ-020 The grant is held for the whole burst; other requesters' valid is ignored until DRAIN completes.
REQ-021 DRAIN: res_valid, res_data and res_id stay stable until res_ready = 1; req_ready is all 0.
REQ-022 DRAIN with res_ready = 1: rr_ptr <= grant+1 (mod NREQ), go to IDLE.
REQ-023 Single-sample burst (first transfer has req_last = 1) yields res_data = ±sample.
REQ-024 Cycles with req_valid[grant] = 0 in ACCUM leave acc unchanged (bubbles allowed).
REQ-025 Minimum burst turnaround: IDLE(1) + N transfer cycles + DRAIN(≥1).
REQ-026 Reset values: req_ready = 0, res_valid = 0, res_data = 0, res_id = 0, rr_ptr = 0, acc = 0.

Reset
REQ-027 Reset asserted in any state, including mid-burst or with res_valid pending, discards partial accumulation and pending result, and returns to IDLE on the next edge.
REQ-028 Reset has priority over every concurrent handshake in the same cycle.

Structure
REQ-029 Shared package accum_pkg holds the state enum, default DW/AW/NREQ constants and the sign-extension helper.
REQ-030 The add/subtract register datapath is the sub-module accum_core (inputs: clear, en, sub, sample; output: acc); the arbiter FSM instantiates it once.

Verification
REQ-031 Requester 2 sends samples 5, 7, -3 (add, last on -3) -> res_valid one cycle after last, res_data = 9, res_id = 2.
REQ-032 Requesters 0 and 1 both valid from reset, each a one-sample burst of 10 -> grant order 0 then 1; res_ids 0, 1 with data 10, 10; then requester 0 again only after requester 1.
REQ-033 Requester 0: add 100, subtract 250 (last) -> res_data = -150; hold res_ready low 5 cycles -> outputs stable and req_ready all 0 throughout.
REQ-034 Accumulate +2^19-1 repeatedly past 2^37 -> res_data wraps modulo 2^38 with no error.
REQ-035 Assert reset mid-burst after 3 samples -> next edge is IDLE with outputs at reset values; the next burst starts from acc = 0.
REQ-036 Bubbles: req_valid[grant] toggled 1,0,0,1 with samples 4, 6 -> res_data = 10.
